// File: rtl/bus_pkg.sv
// Shared cache/bus protocol definitions: tag field layout, line geometry, responder FSM states.
// Latency: none (package only).
// Backpressure: none (package only).
package bus_pkg;

    // Tag layout: [12] write flag, [11:8] device id, [7:0] transaction id
    localparam int WRITE_BIT = 12;
    localparam int DEV_HI    = 11;
    localparam int DEV_LO    = 8;
    localparam int ID_HI     = 7;
    localparam int ID_LO     = 0;

    // A line is eight 64-bit beats (64 bytes)
    localparam int BEATS_PER_LINE = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        RWAIT = 2'd2,
        RESP  = 2'd3
    } state_e;

    // True when the tag's device field names the given device
    function automatic logic dev_match(input logic [12:0] tag, input logic [3:0] dev);
        return tag[DEV_HI:DEV_LO] == dev;
    endfunction

endpackage

// File: rtl/line_store.sv
// Line store: single-port RAM addressed by {line index, beat}, one bus beat per word.
// Latency: writes commit at the clock edge; read data is valid the cycle after the address.
// Backpressure: none; a write cycle leaves the read register holding its previous value.
module line_store #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rdata_q;

    // One port: a cycle either writes a beat or reads one into the output register.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end else begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_mem_responder.sv
// Memory-side bus responder: serves line-sized reads and writes from an on-chip line store.
// Latency: first read beat READ_LATENCY+1 cycles after the request is accepted, then one beat per respack.
// Backpressure: write beats stall while reqcyc is low; read beats hold stable while respack is low.
module bus_mem_responder
    import bus_pkg::*;
#(
    parameter int          BUS_DATA_WIDTH     = 64,
    parameter int          BUS_TAG_WIDTH      = 13,
    parameter logic [3:0]  MEM_DEV_ID         = 4'h1,
    parameter int          LOG_BEATS_PER_LINE = 3,
    parameter int          LOG_NUM_LINES      = 8,
    parameter int          READ_LATENCY       = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_reqack,
    output logic                      bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      bus_respack
);

    localparam int LB        = LOG_BEATS_PER_LINE;
    localparam int LN        = LOG_NUM_LINES;
    // Byte offset within a line: bytes per beat times beats per line
    localparam int LINE_OFF  = $clog2(BUS_DATA_WIDTH / 8) + LB;
    localparam int LAT_W     = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [LB-1:0]    LAST_BEAT = LB'(BEATS_PER_LINE - 1);
    localparam logic [LB-1:0]    BEAT_ONE  = LB'(1);
    localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(READ_LATENCY - 1);

    state_e                    state_q, state_d;
    logic [LN-1:0]             idx_q, idx_d;
    logic [BUS_TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [LB-1:0]             cnt_q, cnt_d;
    logic [LAT_W-1:0]          lat_q, lat_d;
    logic                      respcyc_q, respcyc_d;
    logic [BUS_DATA_WIDTH-1:0] resp_q, resp_d;
    logic [BUS_TAG_WIDTH-1:0]  resptag_q, resptag_d;

    logic [LN-1:0]             req_idx;
    logic                      req_xfer;
    logic                      resp_xfer;
    logic                      mem_we;
    logic [LN-1:0]             rd_idx;
    logic [LB-1:0]             rd_beat;
    logic [LN+LB-1:0]          mem_addr;
    logic [BUS_DATA_WIDTH-1:0] mem_rdata;

    assign req_idx   = bus_req[LINE_OFF +: LN];
    assign req_xfer  = bus_reqcyc && bus_reqack;
    assign resp_xfer = respcyc_q && bus_respack;

    // Accept a new request only for our device while idle; accept every write beat while in WDATA.
    always_comb begin
        bus_reqack = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE:    bus_reqack = bus_reqcyc && dev_match(bus_reqtag, MEM_DEV_ID);
                WDATA:   bus_reqack = bus_reqcyc;
                default: bus_reqack = 1'b0;
            endcase
        end
    end

    // Transaction FSM: next state, beat/latency counters and the registered response beat.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tag_d     = tag_q;
        cnt_d     = cnt_q;
        lat_d     = lat_q;
        respcyc_d = respcyc_q;
        resp_d    = resp_q;
        resptag_d = resptag_q;
        case (state_q)
            IDLE: begin
                if (req_xfer) begin
                    idx_d   = req_idx;
                    tag_d   = bus_reqtag;
                    cnt_d   = '0;
                    lat_d   = '0;
                    state_d = bus_reqtag[WRITE_BIT] ? WDATA : RWAIT;
                end
            end
            WDATA: begin
                if (req_xfer) begin
                    cnt_d = cnt_q + BEAT_ONE;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = IDLE;
                    end
                end
            end
            RWAIT: begin
                if (lat_q == LAT_LAST) begin
                    // Read register already holds beat 0, issued one cycle earlier
                    cnt_d     = '0;
                    state_d   = RESP;
                    respcyc_d = 1'b1;
                    resp_d    = mem_rdata;
                    resptag_d = {tag_q[WRITE_BIT], tag_q[DEV_HI:DEV_LO], tag_q[ID_HI:ID_LO]};
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            RESP: begin
                if (resp_xfer) begin
                    cnt_d  = cnt_q + BEAT_ONE;
                    resp_d = mem_rdata;
                    if (cnt_q == LAST_BEAT) begin
                        state_d   = IDLE;
                        respcyc_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Store addressing: writes go to the current beat; reads run one beat ahead of what the
    // response register will need next, so the RAM's read register never stalls a burst.
    always_comb begin
        mem_we  = (state_q == WDATA) && req_xfer;
        rd_idx  = (state_q == IDLE) ? req_idx : idx_q;
        rd_beat = (state_d == RESP) ? (cnt_d + BEAT_ONE) : '0;
        if (mem_we) begin
            mem_addr = {idx_q, cnt_q};
        end else begin
            mem_addr = {rd_idx, rd_beat};
        end
    end

    line_store #(
        .DATA_W (BUS_DATA_WIDTH),
        .ADDR_W (LN + LB)
    ) u_line_store (
        .clk     (clk),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (bus_req),
        .rdata_o (mem_rdata)
    );

    // State registers; reset abandons any transaction in flight but leaves the store alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            tag_q     <= '0;
            cnt_q     <= '0;
            lat_q     <= '0;
            respcyc_q <= 1'b0;
            resp_q    <= '0;
            resptag_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tag_q     <= tag_d;
            cnt_q     <= cnt_d;
            lat_q     <= lat_d;
            respcyc_q <= respcyc_d;
            resp_q    <= resp_d;
            resptag_q <= resptag_d;
        end
    end

    assign bus_respcyc = respcyc_q;
    assign bus_resp    = resp_q;
    assign bus_resptag = resptag_q;

endmodule
